// File: rtl/case_conv_pkg.sv
// Shared constants, the byte type and the case-restore helpers used by the
// case_restore_stream slice.
package case_conv_pkg;

   typedef logic [7:0] byte_t;

   localparam int    CASE_BIT   = 5;
   localparam byte_t ASCII_LC_A = 8'h61;
   localparam byte_t ASCII_LC_Z = 8'h7A;

   // Put the original case back: bit 5 is the inverse of the converter flag.
   function automatic byte_t restore_byte(byte_t flipped, logic cap);
      byte_t r;
      r           = flipped;
      r[CASE_BIT] = ~cap;
      return r;
   endfunction

   // True when the byte, forced to lower case, is a letter a..z.
   function automatic logic is_lower_alpha(byte_t b);
      byte_t lc;
      lc           = b;
      lc[CASE_BIT] = 1'b1;
      return (lc >= ASCII_LC_A) && (lc <= ASCII_LC_Z);
   endfunction

endpackage

// File: rtl/case_restore_stream_if.sv
// Upstream and downstream valid/ready channels of case_restore_stream.
// slave  : view of the restore block
// master : view of the environment around it
interface case_restore_stream_if import case_conv_pkg::*; ;

   logic  in_valid;
   logic  in_ready;
   byte_t in_data;
   logic  in_cap;
   logic  out_valid;
   logic  out_ready;
   byte_t out_data;

   modport slave (
      input  in_valid, in_data, in_cap, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, in_cap, out_ready,
      input  in_ready, out_valid, out_data
   );

endinterface

// File: rtl/case_restore_fifo.sv
// DEPTH-entry synchronous FIFO with a registered head byte.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module case_restore_fifo import case_conv_pkg::*; #(
   parameter int DEPTH = 2
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  byte_t wdata,
   input  logic  pop,
   output logic  full,
   output logic  empty,
   output byte_t head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   byte_t       mem_q [DEPTH];
   byte_t       mem_d [DEPTH];
   byte_t       head_q, head_d;

   // Pointer advance, storage write and look-ahead of the next head entry.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      // Reading through mem_d lets a byte pushed into an empty FIFO become
      // the head on the same edge it is stored.
      head_d = mem_d[rd_ptr_d[AW-1:0]];
   end

   // Pointer and head registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

   // Storage needs no reset: entries are only visible once written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = head_q;

endmodule

// File: rtl/case_restore_stream.sv
// Restores the original case of bytes coming from the case converter and
// buffers them for the downstream consumer; counts accepted and rewritten
// bytes.
// Optional build macro CASE_RESTORE_ALPHA_ONLY_EN: only letters a..z/A..Z get
// bit 5 rewritten; every other byte passes through untouched.
module case_restore_stream import case_conv_pkg::*; #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   case_restore_stream_if.slave   s,
   input  logic                   clr_cnt,
   output logic [CNT_W-1:0]       byte_cnt,
   output logic [CNT_W-1:0]       cap_cnt
);

   logic             fifo_full;
   logic             fifo_empty;
   byte_t            fifo_head;
   logic             accept;
   logic             drain;
   logic             rewrite;
   byte_t            restored;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0] cap_cnt_q,  cap_cnt_d;

   // Ready depends only on registered occupancy (and reset), never on
   // out_ready, so a pop while full frees the slot one cycle later.
   assign s.in_ready  = ~rst & ~fifo_full;
   assign s.out_valid = ~rst & ~fifo_empty;
   assign s.out_data  = fifo_head;

   assign accept = s.in_valid & s.in_ready;
   assign drain  = s.out_valid & s.out_ready;

   // Decide whether this byte gets bit 5 rewritten and build the restored byte.
   always_comb begin
`ifdef CASE_RESTORE_ALPHA_ONLY_EN
      rewrite = is_lower_alpha(s.in_data);
`else
      rewrite = 1'b1;
`endif
      restored = s.in_data;
      if (rewrite) begin
         restored = restore_byte(s.in_data, s.in_cap);
      end
   end

   case_restore_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .wdata (restored),
      .pop   (drain),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Saturating status counters; a clear overrides a coincident acceptance.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      cap_cnt_d  = cap_cnt_q;
      if (clr_cnt) begin
         byte_cnt_d = '0;
         cap_cnt_d  = '0;
      end else if (accept) begin
         if (byte_cnt_q != '1) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
         end
         if (rewrite && s.in_cap && (cap_cnt_q != '1)) begin
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q <= '0;
         cap_cnt_q  <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
      end
   end

   assign byte_cnt = byte_cnt_q;
   assign cap_cnt  = cap_cnt_q;

endmodule

// File: doc/case_restore_stream.md
CASE_RESTORE_STREAM -- requirements
Module: case_restore_stream

Interface
REQ-001 SHALL have parameter DEPTH, default 2; output buffer entries, power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default 16; width of both status counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream byte present.
REQ-006 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-007 SHALL have port in_data  input  8  case-flipped byte from the converter.
REQ-008 SHALL have port in_cap  input  1  converter flag; 1 = original byte had bit 5 clear.
REQ-009 SHALL have port out_valid  output  1  restored byte present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts.
REQ-011 SHALL have port out_data  output  8  restored original byte.
REQ-012 SHALL have port clr_cnt  input  1  synchronous clear of both counters.
REQ-013 SHALL have port byte_cnt  output  CNT_W  bytes accepted since reset/clear.
REQ-014 SHALL have port cap_cnt  output  CNT_W  accepted bytes with in_cap=1 that were rewritten.

Function
REQ-015 SHALL accept a byte when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 SHALL compute restored byte = {in_data[7:6], ~in_cap, in_data[4:0]}; bits other than 5 pass unchanged.
REQ-017 SHALL write the restored byte into a DEPTH-entry FIFO at acceptance; out_data is the FIFO head, registered.
REQ-018 SHALL have latency of one cycle: byte accepted in cycle N is presented with out_valid=1 in cycle N+1 at earliest.
REQ-019 SHALL drive in_ready = (occupancy < DEPTH) from registered state only; no combinational path from out_ready to in_ready.
REQ-020 SHALL, when full and a pop occurs, hold in_ready=0 that cycle and assert it the next.
REQ-021 SHALL, on simultaneous push and pop with 0 < occupancy < DEPTH, keep occupancy unchanged and preserve order.
REQ-022 SHALL, when empty, hold out_valid=0; out_data content is don't-care.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL wrap read/write pointers modulo DEPTH with one extra bit to distinguish full from empty.
REQ-025 SHALL increment byte_cnt per accepted byte, and cap_cnt per accepted byte whose bit 5 was rewritten with in_cap=1; both saturate at all-ones.
REQ-026 SHALL, when clr_cnt and an acceptance coincide, leave counters at 0 (clear wins); FIFO unaffected by clr_cnt.

Reset
REQ-027 SHALL, while rst=1, force occupancy 0, out_valid=0, in_ready=0, byte_cnt=0, cap_cnt=0, pointers 0.
REQ-028 SHALL assert in_ready=1 in the first cycle after rst deasserts.
REQ-029 SHALL discard buffered bytes on reset mid-stream; no byte accepted during the rst cycle.

Configuration
REQ-030 SHALL, with CASE_RESTORE_ALPHA_ONLY_EN defined, rewrite bit 5 only when {in_data[7:6], 1'b1, in_data[4:0]} is in 'a'..'z' (0x61..0x7A); other bytes pass unchanged and do not count in cap_cnt.
REQ-031 SHALL, without CASE_RESTORE_ALPHA_ONLY_EN, rewrite bit 5 on every byte per REQ-016.

Structure
REQ-032 SHALL place in package case_conv_pkg: CASE_BIT (5), ASCII_LC_A (0x61), ASCII_LC_Z (0x7A), byte typedef.
REQ-033 SHALL instantiate one sub-module case_restore_fifo (DEPTH-entry synchronous FIFO, registered head); restore logic and counters stay in the top.

Verification
REQ-034 SHALL cover: reset release, push in_data=0x61 in_cap=1, out_ready=1 -> next cycle out_valid=1, out_data=0x41, byte_cnt=1, cap_cnt=1.
REQ-035 SHALL cover: out_ready=0, push 0x41/0, 0x62/0, 0x63/1 with DEPTH=2 -> in_ready=0 after two; third held; release -> outputs 0x61, 0x62, 0x43 in order.
REQ-036 SHALL cover: push 0x31 in_cap=1 -> out_data 0x11 without macro, 0x31 and cap_cnt unchanged with CASE_RESTORE_ALPHA_ONLY_EN.
REQ-037 SHALL cover: continuous push/pop with out_ready=1 for 100 bytes -> one byte per cycle, no bubbles, byte_cnt=100.
REQ-038 SHALL cover: rst pulsed with 2 bytes buffered -> out_valid=0 next cycle, counters 0, later bytes unaffected.
REQ-039 SHALL cover: clr_cnt coinciding with acceptance -> byte_cnt=0; CNT_W=4 with 20 bytes -> byte_cnt saturates at 15.
